// File: rtl/tlb_maint_unit.sv
// tlb_maint_unit
//   Executes LoongArch TLB maintenance operations (TLBWR, TLBFILL, TLBRD,
//   TLBSRCH, INVTLB). Keeps the only shadow copy of every TLB entry so that
//   reads, searches and invalidates never need a read port on the mmu, and
//   is the sole writer of mmu TLB state through tlb_write_req_o.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_op            0 TLBWR, 1 TLBFILL, 2 TLBRD, 3 TLBSRCH, 4 INVTLB, 5-7 illegal
//   req_index         TLBIDX.index for TLBWR/TLBRD
//   req_entry         entry to write for TLBWR/TLBFILL
//   srch_asid         ASID for TLBSRCH and INVTLB ops 4-6
//   srch_va           VA for TLBSRCH and INVTLB ops 5/6
//   inv_op            INVTLB op code
//   tlb_write_req_o   registered one-hot write strobe + entry to the mmu
//   done_valid        one-cycle completion pulse
//   done_err          INE (illegal req_op or inv_op > 6), valid with done_valid
//   rd_entry          TLBRD result, valid with done_valid
//   srch_hit/index    TLBSRCH result (lowest matching index), valid with done_valid

`ifndef _TLB_ENTRY_NUM
`define _TLB_ENTRY_NUM 32
`endif

package tlb_maint_pkg;
  localparam int TLB_N = `_TLB_ENTRY_NUM;

  // ps == 21 marks a huge page; its vppn compare uses only vppn[18:9].
  typedef struct packed {
    logic        e;
    logic [9:0]  asid;
    logic        g;
    logic [5:0]  ps;
    logic [18:0] vppn;
    logic        v0;
    logic        d0;
    logic [1:0]  mat0;
    logic [1:0]  plv0;
    logic [19:0] ppn0;
    logic        v1;
    logic        d1;
    logic [1:0]  mat1;
    logic [1:0]  plv1;
    logic [19:0] ppn1;
  } tlb_entry_t;

  typedef struct packed {
    logic [TLB_N-1:0] strobe;
    tlb_entry_t       entry;
  } tlb_write_req_t;
endpackage

module tlb_maint_unit
  import tlb_maint_pkg::*;
#(
  parameter int TLB_ENTRY_NUM = `_TLB_ENTRY_NUM,
  localparam int IDX_W = $clog2(TLB_ENTRY_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [IDX_W-1:0] req_index,
  input  tlb_entry_t       req_entry,
  input  logic [9:0]       srch_asid,
  input  logic [31:0]      srch_va,
  input  logic [4:0]       inv_op,
  output tlb_write_req_t   tlb_write_req_o,
  output logic             done_valid,
  output logic             done_err,
  output tlb_entry_t       rd_entry,
  output logic             srch_hit,
  output logic [IDX_W-1:0] srch_index
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_EXEC, S_INV, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRY_NUM - 1);
  localparam logic [2:0] OP_WR   = 3'd0;
  localparam logic [2:0] OP_FILL = 3'd1;
  localparam logic [2:0] OP_RD   = 3'd2;
  localparam logic [2:0] OP_SRCH = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] fill_cnt;
  logic [IDX_W-1:0] index_q;
  logic             inv_tail;
  logic [2:0]       op_q;
  tlb_entry_t       entry_q;
  logic [9:0]       asid_q;
  logic [18:0]      vpn_q;
  logic [4:0]       inv_op_q;
  tlb_entry_t       shadow [TLB_ENTRY_NUM];

  // Only the VPN bits of the VA take part in any compare.
  logic unused_va_lo;
  assign unused_va_lo = ^srch_va[12:0];

  function automatic logic va_hit(tlb_entry_t en, logic [18:0] vpn);
    logic r;
    if (en.ps == 6'd21) r = (vpn[18:9] == en.vppn[18:9]);
    else                r = (vpn == en.vppn);
    return r;
  endfunction

  function automatic logic inv_hit(tlb_entry_t en, logic [4:0] op,
                                   logic [9:0] asid, logic [18:0] vpn);
    logic asid_eq;
    logic va_eq;
    logic r;
    asid_eq = (en.asid == asid);
    va_eq   = va_hit(en, vpn);
    case (op)
      5'd0, 5'd1: r = 1'b1;
      5'd2:       r = en.g;
      5'd3:       r = ~en.g;
      5'd4:       r = ~en.g & asid_eq;
      5'd5:       r = ~en.g & asid_eq & va_eq;
      5'd6:       r = (en.g | asid_eq) & va_eq;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

  // Descending scan so the lowest matching index is the one that sticks.
  logic             srch_hit_c;
  logic [IDX_W-1:0] srch_idx_c;
  always_comb begin
    srch_hit_c = 1'b0;
    srch_idx_c = '0;
    for (int i = TLB_ENTRY_NUM - 1; i >= 0; i--) begin
      if (shadow[i].e && (shadow[i].g || shadow[i].asid == asid_q) &&
          va_hit(shadow[i], vpn_q)) begin
        srch_hit_c = 1'b1;
        srch_idx_c = IDX_W'(i);
      end
    end
  end

  // idx is 0 whenever EXEC is entered, so the same step handles the first
  // invalidate entry in EXEC and the rest in INV.
  logic       inv_hit_c;
  tlb_entry_t inv_entry_c;
  always_comb begin
    inv_entry_c   = shadow[idx];
    inv_entry_c.e = 1'b0;
    inv_hit_c     = inv_hit(shadow[idx], inv_op_q, asid_q, vpn_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_INIT;
      idx             <= '0;
      fill_cnt        <= '0;
      inv_tail        <= 1'b0;
      index_q         <= '0;
      op_q            <= '0;
      entry_q         <= '0;
      asid_q          <= '0;
      vpn_q           <= '0;
      inv_op_q        <= '0;
      req_ready       <= 1'b0;
      done_valid      <= 1'b0;
      done_err        <= 1'b0;
      rd_entry        <= '0;
      srch_hit        <= 1'b0;
      srch_index      <= '0;
      tlb_write_req_o <= '0;
      for (int i = 0; i < TLB_ENTRY_NUM; i++) shadow[i].e <= 1'b0;
    end else begin
      tlb_write_req_o <= '0;
      done_valid      <= 1'b0;
      case (state)
        S_INIT: begin
          // Shadow mirrors the all-zero entries written to the mmu.
          shadow[idx]                  <= '0;
          tlb_write_req_o.strobe[idx]  <= 1'b1;
          idx                          <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            index_q   <= req_index;
            entry_q   <= req_entry;
            asid_q    <= srch_asid;
            vpn_q     <= srch_va[31:13];
            inv_op_q  <= inv_op;
            req_ready <= 1'b0;
            state     <= S_EXEC;
          end else begin
            fill_cnt <= fill_cnt + IDX_W'(1);
          end
        end
        S_EXEC: begin
          done_err   <= 1'b0;
          rd_entry   <= '0;
          srch_hit   <= 1'b0;
          srch_index <= '0;
          state      <= S_DONE;
          done_valid <= 1'b1;
          case (op_q)
            OP_WR: begin
              shadow[index_q]                 <= entry_q;
              tlb_write_req_o.strobe[index_q] <= 1'b1;
              tlb_write_req_o.entry           <= entry_q;
            end
            OP_FILL: begin
              shadow[fill_cnt]                 <= entry_q;
              tlb_write_req_o.strobe[fill_cnt] <= 1'b1;
              tlb_write_req_o.entry            <= entry_q;
              fill_cnt                         <= fill_cnt + IDX_W'(1);
            end
            OP_RD: begin
              if (shadow[index_q].e) rd_entry <= shadow[index_q];
            end
            OP_SRCH: begin
              srch_hit   <= srch_hit_c;
              srch_index <= srch_idx_c;
            end
            OP_INV: begin
              if (inv_op_q <= 5'd6) begin
                state      <= S_INV;
                done_valid <= 1'b0;
                if (inv_hit_c) begin
                  shadow[idx].e               <= 1'b0;
                  tlb_write_req_o.strobe[idx] <= 1'b1;
                  tlb_write_req_o.entry       <= inv_entry_c;
                end
                idx <= idx + IDX_W'(1);
              end else begin
                done_err <= 1'b1;
              end
            end
            default: done_err <= 1'b1;
          endcase
        end
        S_INV: begin
          // The tail cycle lets the last strobe land before done_valid.
          if (inv_tail) begin
            inv_tail   <= 1'b0;
            state      <= S_DONE;
            done_valid <= 1'b1;
          end else begin
            if (inv_hit_c) begin
              shadow[idx].e               <= 1'b0;
              tlb_write_req_o.strobe[idx] <= 1'b1;
              tlb_write_req_o.entry       <= inv_entry_c;
            end
            idx <= idx + IDX_W'(1);
            if (idx == LAST_IDX) inv_tail <= 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_maint_unit.sv
module tb_tlb_maint_unit;
  import tlb_maint_pkg::*;

  localparam int N  = TLB_N;
  localparam int IW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [2:0]     req_op;
  logic [IW-1:0]  req_index;
  tlb_entry_t     req_entry;
  logic [9:0]     srch_asid;
  logic [31:0]    srch_va;
  logic [4:0]     inv_op;
  tlb_write_req_t wr_req;
  logic           done_valid;
  logic           done_err;
  tlb_entry_t     rd_entry;
  logic           srch_hit;
  logic [IW-1:0]  srch_index;

  tlb_maint_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_index(req_index), .req_entry(req_entry),
    .srch_asid(srch_asid), .srch_va(srch_va), .inv_op(inv_op),
    .tlb_write_req_o(wr_req), .done_valid(done_valid), .done_err(done_err),
    .rd_entry(rd_entry), .srch_hit(srch_hit), .srch_index(srch_index)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         fill_m = 0;
  tlb_entry_t sh [N];

  // Reference fill counter: +1 per idle cycle in which no request is taken,
  // +1 per accepted TLBFILL.
  always @(posedge clk) begin
    if (rst) fill_m <= 0;
    else if (req_ready && (!req_valid || req_op == 3'd1)) fill_m <= (fill_m + 1) % N;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_va_hit(tlb_entry_t en, logic [31:0] va);
    if (en.ps == 6'd21) return (va >> 22) == (32'(en.vppn) >> 9);
    return (va >> 13) == 32'(en.vppn);
  endfunction

  function automatic logic m_inv_hit(tlb_entry_t en, int op, logic [9:0] a, logic [31:0] va);
    logic ae;
    ae = (en.asid == a);
    case (op)
      0, 1:    return 1'b1;
      2:       return en.g;
      3:       return !en.g;
      4:       return !en.g && ae;
      5:       return !en.g && ae && m_va_hit(en, va);
      6:       return (en.g || ae) && m_va_hit(en, va);
      default: return 1'b0;
    endcase
  endfunction

  function automatic tlb_entry_t rnd_entry(input logic [9:0] a);
    tlb_entry_t x;
    x      = '0;
    x.e    = ($urandom_range(0, 3) != 0);
    x.asid = a;
    x.g    = ($urandom_range(0, 3) == 0);
    x.ps   = ($urandom_range(0, 1) == 1) ? 6'd21 : 6'd12;
    x.vppn = 19'($urandom_range(0, 3) * 512 + $urandom_range(0, 1));
    x.ppn0 = 20'($urandom);
    x.ppn1 = 20'($urandom);
    x.v0   = 1'($urandom);
    x.d1   = 1'($urandom);
    x.mat0 = 2'($urandom);
    x.plv1 = 2'($urandom);
    return x;
  endfunction

  // After rst is released at a negedge: strobes 0..N-1 on consecutive cycles.
  task automatic init_check();
    logic [N-1:0] oh;
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      oh = '0;
      oh[k-1] = 1'b1;
      chk($sformatf("init_stb_%0d", k - 1), 128'({done_valid, wr_req.strobe}), 128'({1'b0, oh}));
      chk($sformatf("init_ent_%0d", k - 1), 128'(wr_req.entry), 128'(0));
      if (k < N) chk($sformatf("init_rdy_%0d", k - 1), 128'(req_ready), 128'(0));
    end
    for (int i = 0; i < N; i++) sh[i] = '0;
  endtask

  // Waits for ready, optional idle cycles / fill alignment, then handshakes.
  // Returns at the negedge of cycle T+1 with the fill index in effect.
  task automatic issue(input logic [2:0] op, input int index, input tlb_entry_t ent,
                       input logic [9:0] a, input logic [31:0] va, input logic [4:0] iop,
                       input int fill_target, input int idle, output int fidx);
    int w;
    w = 0;
    do begin @(negedge clk); w++; end while (req_ready !== 1'b1 && w < 200);
    chk("ready_wait", 128'(req_ready), 128'(1));
    repeat (idle) @(negedge clk);
    if (fill_target >= 0) begin
      w = 0;
      while (fill_m != fill_target && w < 100) begin @(negedge clk); w++; end
      chk("fill_align_timeout", 128'(w < 100), 128'(1));
    end
    fidx      = fill_m;
    req_op    = op;
    req_index = IW'(index);
    req_entry = ent;
    srch_asid = a;
    srch_va   = va;
    inv_op    = iop;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input int index, input tlb_entry_t ent,
                        input logic [9:0] a, input logic [31:0] va, input logic [4:0] iop,
                        input int fill_target, input int idle);
    logic [N-1:0] es [N+3];
    tlb_entry_t   ee [N+3];
    int           done_k, fidx, widx, exp_idx;
    logic         exp_err, exp_hit;
    tlb_entry_t   exp_rd;
    issue(op, index, ent, a, va, iop, fill_target, idle, fidx);
    for (int k = 0; k < N + 3; k++) begin es[k] = '0; ee[k] = '0; end
    done_k = 2; exp_err = 1'b0; exp_hit = 1'b0; exp_idx = 0; exp_rd = '0;
    case (op)
      3'd0, 3'd1: begin
        widx = (op == 3'd0) ? index : fidx;
        sh[widx] = ent;
        es[2][widx] = 1'b1;
        ee[2] = ent;
      end
      3'd2: exp_rd = sh[index].e ? sh[index] : '0;
      3'd3: begin
        for (int i = 0; i < N; i++)
          if (!exp_hit && sh[i].e && (sh[i].g || sh[i].asid == a) && m_va_hit(sh[i], va)) begin
            exp_hit = 1'b1;
            exp_idx = i;
          end
      end
      3'd4: begin
        if (iop > 5'd6) exp_err = 1'b1;
        else begin
          done_k = N + 2;
          for (int i = 0; i < N; i++)
            if (m_inv_hit(sh[i], int'(iop), a, va)) begin
              sh[i].e = 1'b0;
              es[2+i][i] = 1'b1;
              ee[2+i] = sh[i];
            end
        end
      end
      default: exp_err = 1'b1;
    endcase
    for (int k = 1; k <= done_k; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("op%0d_c%0d_done_stb", op, k), 128'({done_valid, wr_req.strobe}),
          128'({(k == done_k), es[k]}));
      if (es[k] != '0) chk($sformatf("op%0d_c%0d_entry", op, k), 128'(wr_req.entry), 128'(ee[k]));
    end
    chk($sformatf("op%0d_err", op), 128'(done_err), 128'(exp_err));
    if (op == 3'd2) chk("rd_entry", 128'(rd_entry), 128'(exp_rd));
    if (op == 3'd3) chk("srch", 128'({srch_hit, srch_index}), 128'({exp_hit, IW'(exp_idx)}));
  endtask

  initial begin
    tlb_entry_t e;
    int         fidx, sel, pick;
    logic [2:0] op;
    logic [31:0] va;

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_index = '0; req_entry = '0;
    srch_asid = '0; srch_va = '0; inv_op = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 128'({req_ready, done_valid, done_err, srch_hit, srch_index, wr_req.strobe}), 128'(0));
    chk("reset_ent", 128'({rd_entry, wr_req.entry}), 128'(0));
    rst = 1'b0;
    init_check();

    // TLBWR idx 5 then TLBSRCH
    e = '0; e.e = 1'b1; e.vppn = 19'h12345; e.ps = 6'd12; e.asid = 10'd3; e.ppn0 = 20'hABCDE;
    run_op(3'd0, 5, e, 0, 0, 0, -1, 0);
    run_op(3'd3, 0, '0, 10'd3, 32'h2468A000, 0, -1, 0);
    run_op(3'd3, 0, '0, 10'd4, 32'h2468C000, 0, -1, 1);

    // TLBFILL x3 from counter 31: indices 31, 0, 1
    for (int f = 0; f < 3; f++) begin
      e = rnd_entry(10'd1); e.e = 1'b1; e.g = 1'b0;
      run_op(3'd1, 0, e, 0, 0, 0, (f == 0) ? N - 1 : -1, 0);
    end
    run_op(3'd2, N - 1, '0, 0, 0, 0, -1, 0);
    run_op(3'd2, 1, '0, 0, 0, 0, -1, 2);

    // INVTLB op 4 asid 7
    e = rnd_entry(10'd7); e.e = 1'b1; e.g = 1'b0; run_op(3'd0, 2, e, 0, 0, 0, -1, 0);
    e = rnd_entry(10'd7); e.e = 1'b1; e.g = 1'b1; run_op(3'd0, 3, e, 0, 0, 0, -1, 0);
    e = rnd_entry(10'd8); e.e = 1'b1; e.g = 1'b0; run_op(3'd0, 9, e, 0, 0, 0, -1, 0);
    run_op(3'd4, 0, '0, 10'd7, 0, 5'd4, -1, 0);
    run_op(3'd2, 2, '0, 0, 0, 0, -1, 0);
    run_op(3'd2, 3, '0, 0, 0, 0, -1, 0);
    run_op(3'd2, 9, '0, 0, 0, 0, -1, 0);

    // Illegal ops
    run_op(3'd4, 0, '0, 0, 0, 5'd7, -1, 0);
    run_op(3'd6, 0, '0, 0, 0, 0, -1, 0);
    run_op(3'd5, 0, '0, 0, 0, 0, -1, 1);

    // Randomized mix against the model
    for (int r = 0; r < 40; r++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    op = 3'd0;
        2, 3:    op = 3'd1;
        4, 5:    op = 3'd2;
        6, 7:    op = 3'd3;
        8:       op = 3'd4;
        default: op = 3'($urandom_range(5, 7));
      endcase
      pick = $urandom_range(0, N - 1);
      va = {sh[pick].vppn, 13'($urandom_range(0, 8191))};
      if ($urandom_range(0, 3) == 0) va = $urandom;
      run_op(op, $urandom_range(0, N - 1), rnd_entry(10'($urandom_range(0, 3))),
             10'($urandom_range(0, 3)), va, 5'($urandom_range(0, 7)), -1, $urandom_range(0, 3));
    end

    // Reset during an INVTLB sweep at idx 10
    issue(3'd4, 0, '0, 0, 0, 5'd0, -1, 0, fidx);
    repeat (11) @(negedge clk);
    chk("abort_pre_stb", 128'(wr_req.strobe), 128'(32'h0000_0400));
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", 128'({done_valid, req_ready, wr_req.strobe}), 128'(0));
    end
    rst = 1'b0;
    init_check();
    run_op(3'd2, 5, '0, 0, 0, 0, -1, 0);
    run_op(3'd3, 0, '0, 10'd3, 32'h2468A000, 0, -1, 0);
    e = rnd_entry(10'd2); e.e = 1'b1;
    run_op(3'd1, 0, e, 0, 0, 0, -1, 3);
    run_op(3'd4, 0, '0, 10'd2, {e.vppn, 13'd0}, 5'd6, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
